idu: RTL and testbench
======================

Name: idu

Overview:
- Instruction decode stage of the NPC core, directly downstream of the fetch stage.
- Captures the fetched instruction word and its PC on the fetch stage's one-cycle valid pulse.
- Decodes RV32I base instructions into register indices, a sign-extended immediate, an ALU op and control flags.
- Holds the decoded bundle with a valid/ready handshake until the execute stage accepts it.

Parameters:
- XLEN, 32, datapath and immediate width.
- RA_W, 5, register index width (4 permitted for RV32E; upper index bits are then ignored, with no illegal check on them).

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- inst  input  XLEN  fetched instruction word; valid only in a cycle where idu_valid=1.
- pc  input  XLEN  PC of inst; same validity as inst.
- idu_valid  input  1  single-cycle pulse from fetch; there is no backpressure toward fetch.
- exu_ready  input  1  execute stage can accept the bundle.
- exu_valid  output  1  decoded bundle valid.
- d_pc  output  XLEN  latched PC.
- rs1, rs2, rd  output  RA_W each  register indices.
- imm  output  XLEN  sign-extended immediate (I/S/B/U/J per opcode, 0 for R-type).
- alu_op  output  4  operation code; encodings are defined in the package.
- is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_ebreak, rf_wen  output  1 each  control flags.
- funct3  output  3  passed through for load/store width and branch condition.
- illegal  output  1  instruction not in the supported set.
- overflow  output  1  sticky: a capture was lost because the bundle was still held.

Behaviour:
- Reset (reset=0, asynchronous): state EMPTY, exu_valid=0, overflow=0, all bundle outputs 0.
- Effect is immediate, including mid-hold; the held bundle is discarded.
- Two states: EMPTY and FULL.
- EMPTY, idu_valid=1: latch pc and the decode of inst at the clock edge; go to FULL.
  - exu_valid rises in the next cycle. Latency is 1 cycle from the idu_valid pulse to exu_valid.
- FULL: exu_valid=1; all bundle outputs stay stable until a handshake (exu_valid & exu_ready).
- FULL, handshake, idu_valid=0: go to EMPTY.
- FULL, handshake, idu_valid=1 in the same cycle: load the new bundle and stay FULL. exu_valid stays 1, so there is no bubble.
- FULL, no handshake, idu_valid=1: the new instruction is dropped and overflow is set.
  - overflow clears only on reset.
  - The held bundle is unchanged.
- All decode is combinational from inst and registered once. Outputs are never driven from the input combinationally.
- Immediates:
  - I: inst[31:20] sign-extended.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All sign-extended to XLEN.
- rf_wen is 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR. It is forced to 0 when rd=0 or illegal=1.
- Supported opcodes:
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - SYSTEM with inst==0x00100073 (ebreak) only.
- Illegal decodes set illegal=1, clear every other flag and set alu_op=ADD. Cases:
  - any other opcode;
  - inst[1:0]!=2'b11;
  - invalid funct3/funct7 combinations, e.g. OP with funct7 not in {0x00, 0x20}, or SUB/SRA funct7 on other funct3 values.
- ALU op selection:
  - LOAD/STORE/JAL/JALR/AUIPC/LUI use ADD.
  - BRANCH uses SUB.
  - OP/OP-IMM derive alu_op from funct3 and inst[30]. inst[30] is ignored for OP-IMM except on SRAI.

Decomposition:
- Shared package npc_pkg holds:
  - opcode constants;
  - the alu_op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND);
  - the immediate-format enum;
  - the EBREAK encoding constant.
- One sub-module, imm_gen: purely combinational; inputs inst and format; output imm.

Test Plan:
- inst=0x00500093 (addi x1,x0,5), pc=0x80000000, idu_valid pulse, exu_ready=1 -> next cycle exu_valid=1, rd=1, rs1=0, imm=5, alu_op=ADD, rf_wen=1, d_pc=0x80000000; the cycle after, exu_valid=0.
- inst=0x12345137 (lui x2,0x12345) -> imm=0x12345000, is_lui=1, rd=2, rf_wen=1.
- inst=0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, is_branch=1, alu_op=SUB, funct3=0, rf_wen=0.
- inst=0x00100073 -> is_ebreak=1, illegal=0; inst=0xFFFFFFFF -> illegal=1, rf_wen=0, all other flags 0.
- Backpressure:
  - Stimulus: exu_ready=0; capture addi; 3 cycles later pulse idu_valid with 0x00000013.
  - Response: the held bundle is unchanged (rd=1), overflow=1.
  - Stimulus: then exu_ready=1.
  - Response: one handshake, then exu_valid=0, overflow still 1.
- Reset mid-hold: assert reset=0 asynchronously between edges while FULL -> exu_valid=0 and overflow=0 immediately; after release, the first idu_valid is captured normally.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared NPC core definitions: opcodes, ALU ops, immediate formats, decode bundle.
package npc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // IMM_R yields a zero immediate.
  typedef enum logic [2:0] {
    IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } idu_state_e;

  // Control half of the decoded bundle.
  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_lui;
    logic       is_auipc;
    logic       is_ebreak;
    logic       rf_wen;
    logic       illegal;
    alu_op_e    alu_op;
    logic [2:0] funct3;
  } ctrl_t;

  // funct3 -> ALU op; alt selects SUB/SRA (inst[30]).
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for the RV32I formats, sign-extended to XLEN.
module imm_gen
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opc;

  // Opcode bits never contribute to an immediate.
  assign unused_opc = ^inst[6:0];

  // Assemble the 32-bit immediate for the selected format.
  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/idu.sv
// Instruction decode stage: captures a fetch pulse, decodes RV32I, holds the
// bundle under a valid/ready handshake toward execute.
module idu
  import npc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] pc,
  input  logic            idu_valid,
  input  logic            exu_ready,
  output logic            exu_valid,
  output logic [XLEN-1:0] d_pc,
  output logic [RA_W-1:0] rs1,
  output logic [RA_W-1:0] rs2,
  output logic [RA_W-1:0] rd,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_lui,
  output logic            is_auipc,
  output logic            is_ebreak,
  output logic            rf_wen,
  output logic [2:0]      funct3,
  output logic            illegal,
  output logic            overflow
);

  logic [31:0]     iw;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [RA_W-1:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] imm_d;
  imm_fmt_e        fmt;
  ctrl_t           ctrl_d, ctrl_q;
  logic            legal, wen;

  idu_state_e      state_q, state_d;
  logic            load, ovf_set;

  logic [XLEN-1:0] pc_q, imm_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic            ovf_q;

  assign iw  = inst[31:0];
  assign opc = iw[6:0];
  assign f3  = iw[14:12];
  assign f7  = iw[31:25];

  // With RA_W<5 the upper index bits are simply dropped.
  assign rs1_d = iw[15 +: RA_W];
  assign rs2_d = iw[20 +: RA_W];
  assign rd_d  = iw[7  +: RA_W];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (iw),
    .fmt  (fmt),
    .imm  (imm_d)
  );

  // Opcode/funct decode; illegal encodings collapse to a flag-free ADD.
  always_comb begin
    ctrl_d        = '0;
    ctrl_d.alu_op = ALU_ADD;
    ctrl_d.funct3 = f3;
    fmt           = IMM_R;
    legal         = 1'b0;
    wen           = 1'b0;
    case (opc)
      OPC_LUI:    begin legal = 1'b1; wen = 1'b1; fmt = IMM_U; ctrl_d.is_lui   = 1'b1; end
      OPC_AUIPC:  begin legal = 1'b1; wen = 1'b1; fmt = IMM_U; ctrl_d.is_auipc = 1'b1; end
      OPC_JAL:    begin legal = 1'b1; wen = 1'b1; fmt = IMM_J; ctrl_d.is_jal   = 1'b1; end
      OPC_JALR: begin
        legal = (f3 == 3'b000); wen = 1'b1; fmt = IMM_I; ctrl_d.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        fmt = IMM_B; ctrl_d.is_branch = 1'b1; ctrl_d.alu_op = ALU_SUB;
      end
      OPC_LOAD: begin
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        wen = 1'b1; fmt = IMM_I; ctrl_d.is_load = 1'b1;
      end
      OPC_STORE: begin
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        fmt = IMM_S; ctrl_d.is_store = 1'b1;
      end
      OPC_OP_IMM: begin
        wen = 1'b1; fmt = IMM_I;
        case (f3)
          3'b001:  legal = (f7 == 7'h00);
          3'b101:  legal = (f7 == 7'h00) || (f7 == 7'h20);
          default: legal = 1'b1;
        endcase
        // inst[30] is an immediate bit except for the right shifts.
        ctrl_d.alu_op = alu_from_f3(f3, (f3 == 3'b101) && iw[30]);
      end
      OPC_OP: begin
        wen   = 1'b1;
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        ctrl_d.alu_op = alu_from_f3(f3, iw[30]);
      end
      OPC_SYSTEM: begin
        legal = (iw == EBREAK_INST); fmt = IMM_I; ctrl_d.is_ebreak = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      ctrl_d         = '0;
      ctrl_d.alu_op  = ALU_ADD;
      ctrl_d.funct3  = f3;
      ctrl_d.illegal = 1'b1;
      fmt            = IMM_R;
    end
    ctrl_d.rf_wen = wen && legal && (rd_d != '0);
  end

  // EMPTY/FULL next state, capture enable and overflow detection.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      ST_EMPTY: if (idu_valid) begin
        load    = 1'b1;
        state_d = ST_FULL;
      end
      ST_FULL: begin
        if (exu_ready) begin
          if (idu_valid) load = 1'b1;
          else           state_d = ST_EMPTY;
        end else if (idu_valid) begin
          ovf_set = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  // Bundle register, only written on capture so it holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      imm_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
    end else if (load) begin
      pc_q   <= pc;
      imm_q  <= imm_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign exu_valid = (state_q == ST_FULL);
  assign overflow  = ovf_q;
  assign d_pc      = pc_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign imm       = imm_q;
  assign alu_op    = ctrl_q.alu_op;
  assign is_load   = ctrl_q.is_load;
  assign is_store  = ctrl_q.is_store;
  assign is_branch = ctrl_q.is_branch;
  assign is_jal    = ctrl_q.is_jal;
  assign is_jalr   = ctrl_q.is_jalr;
  assign is_lui    = ctrl_q.is_lui;
  assign is_auipc  = ctrl_q.is_auipc;
  assign is_ebreak = ctrl_q.is_ebreak;
  assign rf_wen    = ctrl_q.rf_wen;
  assign funct3    = ctrl_q.funct3;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_idu.sv
// Scoreboard bench for idu: directed instructions with hand-decoded bundles.
module tb_idu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst, pc;
  logic        idu_valid, exu_ready;
  logic        exu_valid;
  logic [31:0] d_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_ebreak;
  logic        rf_wen, illegal, overflow;
  logic [2:0]  funct3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [95:0] expq[$];

  localparam logic [9:0] FL_LOAD = 10'h200, FL_STORE = 10'h100, FL_BRANCH = 10'h080,
                         FL_JAL = 10'h040, FL_JALR = 10'h020, FL_LUI = 10'h010,
                         FL_AUIPC = 10'h008, FL_EBREAK = 10'h004, FL_WEN = 10'h002,
                         FL_ILL = 10'h001;

  always #5 clk = ~clk;

  idu dut (
    .clk(clk), .reset(reset), .inst(inst), .pc(pc), .idu_valid(idu_valid),
    .exu_ready(exu_ready), .exu_valid(exu_valid), .d_pc(d_pc), .rs1(rs1), .rs2(rs2),
    .rd(rd), .imm(imm), .alu_op(alu_op), .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .is_lui(is_lui),
    .is_auipc(is_auipc), .is_ebreak(is_ebreak), .rf_wen(rf_wen), .funct3(funct3),
    .illegal(illegal), .overflow(overflow)
  );

  function automatic logic [95:0] got_bundle();
    return {d_pc, rs1, rs2, rd, imm, alu_op,
            {is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_ebreak,
             rf_wen, illegal}, funct3};
  endfunction

  function automatic logic [95:0] mk(input logic [31:0] p, input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [4:0] d, input logic [31:0] im, input logic [3:0] op,
                                     input logic [9:0] fl, input logic [2:0] f3);
    return {p, s1, s2, d, im, op, fl, f3};
  endfunction

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one fetch pulse; entered and left at posedge+1.
  task automatic issue(input logic [31:0] i, input logic [31:0] p);
    inst = i; pc = p; idu_valid = 1'b1;
    @(posedge clk); #1;
    idu_valid = 1'b0;
  endtask

  // Monitor: every handshake pops and compares one expected bundle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && exu_valid && exu_ready) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_bundle: got %h expected none", got_bundle());
        end else begin
          chk("bundle", got_bundle(), expq.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b0; idu_valid = 1'b0; exu_ready = 1'b1; inst = '0; pc = '0;
    #12;
    chk("reset_bundle", got_bundle(), '0);
    chk("reset_valid_ovf", {94'd0, exu_valid, overflow}, '0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Single addi: one-cycle latency, then drains.
    expq.push_back(mk(32'h8000_0000, 5'd0, 5'd5, 5'd1, 32'd5, 4'd0, FL_WEN, 3'd0));
    issue(32'h0050_0093, 32'h8000_0000);
    @(negedge clk); chk("latency_valid", {95'd0, exu_valid}, 96'd1);
    @(negedge clk); chk("drain_valid", {95'd0, exu_valid}, 96'd0);
    @(posedge clk); #1;

    // Back-to-back stream with exu_ready=1: FULL+handshake reloads each cycle.
    expq.push_back(mk(32'h8000_0004, 5'd8,  5'd3,  5'd2,  32'h1234_5000, 4'd0, FL_LUI | FL_WEN, 3'd5));
    expq.push_back(mk(32'h8000_0008, 5'd0,  5'd0,  5'd29, 32'hFFFF_FFFC, 4'd1, FL_BRANCH,       3'd0));
    expq.push_back(mk(32'h8000_000C, 5'd0,  5'd1,  5'd0,  32'd1,         4'd0, FL_EBREAK,       3'd0));
    expq.push_back(mk(32'h8000_0010, 5'd31, 5'd31, 5'd31, 32'd0,         4'd0, FL_ILL,          3'd7));
    expq.push_back(mk(32'h8000_0014, 5'd1,  5'd2,  5'd3,  32'd0,         4'd1, FL_WEN,          3'd0));
    expq.push_back(mk(32'h8000_0018, 5'd1,  5'd2,  5'd24, 32'hFFFF_FFF8, 4'd0, FL_STORE,        3'd2));
    expq.push_back(mk(32'h8000_001C, 5'd0,  5'd16, 5'd1,  32'd16,        4'd0, FL_JAL | FL_WEN, 3'd0));
    expq.push_back(mk(32'h8000_0020, 5'd1,  5'd2,  5'd2,  32'd0,         4'd0, FL_ILL,          3'd1));
    expq.push_back(mk(32'h8000_0024, 5'd5,  5'd3,  5'd5,  32'h0000_0403, 4'd7, FL_WEN,          3'd5));
    issue(32'h1234_5137, 32'h8000_0004);
    issue(32'hFE00_0EE3, 32'h8000_0008);
    issue(32'h0010_0073, 32'h8000_000C);
    issue(32'hFFFF_FFFF, 32'h8000_0010);
    issue(32'h4020_81B3, 32'h8000_0014);
    issue(32'hFE20_AC23, 32'h8000_0018);
    issue(32'h0100_00EF, 32'h8000_001C);
    issue(32'h4020_9133, 32'h8000_0020);
    issue(32'h4032_D293, 32'h8000_0024);
    repeat (2) @(posedge clk);
    #1;
    chk("stream_drained", {95'd0, exu_valid}, 96'd0);

    // Backpressure: second pulse while held is dropped and flags overflow.
    exu_ready = 1'b0;
    expq.push_back(mk(32'h8000_0100, 5'd0, 5'd5, 5'd1, 32'd5, 4'd0, FL_WEN, 3'd0));
    issue(32'h0050_0093, 32'h8000_0100);
    repeat (3) @(posedge clk);
    #1;
    issue(32'h0000_0013, 32'h8000_0104);
    @(negedge clk);
    chk("hold_rd_pc", {59'd0, rd, d_pc}, {59'd0, 5'd1, 32'h8000_0100});
    chk("ovf_set", {94'd0, exu_valid, overflow}, 96'd3);
    @(posedge clk); #1;
    exu_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ovf_sticky", {94'd0, exu_valid, overflow}, 96'd1);
    @(posedge clk); #1;

    // Asynchronous reset while holding a bundle with overflow set.
    exu_ready = 1'b0;
    issue(32'h0050_0093, 32'h8000_0200);
    repeat (2) @(posedge clk);
    #1;
    issue(32'h0000_0013, 32'h8000_0204);
    #2 reset = 1'b0;
    #1;
    chk("rst_async", {61'd0, exu_valid, overflow, rd, d_pc}, '0);
    @(negedge clk); reset = 1'b1; exu_ready = 1'b1;
    @(posedge clk); #1;
    expq.push_back(mk(32'h8000_0300, 5'd8, 5'd3, 5'd2, 32'h1234_5000, 4'd0, FL_LUI | FL_WEN, 3'd5));
    issue(32'h1234_5137, 32'h8000_0300);
    @(negedge clk);
    chk("post_rst_latency", {95'd0, exu_valid}, 96'd1);

    // Bounded wait for the scoreboard to empty.
    for (int k = 0; k < 20 && expq.size() != 0; k++) @(posedge clk);
    #1;
    chk("scoreboard_empty", 96'(expq.size()), '0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
